srec_word_packer: RTL and testbench

Consumes the byte-write stream produced by the SREC parser (address, byte, one-cycle enable) and packs bytes into aligned 32-bit little-endian words with byte enables. Completed words are buffered in a small FIFO and presented on a valid/ready port to the downstream memory or bus writer. The upstream source cannot be stalled, so overflow is flagged rather than back-pressured.

---
 rtl/srec_word_packer.sv | 192 +++++++++++++++++++
 tb/tb_srec_word_packer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/srec_word_packer.sv
// ---------------------------------------------------------------------------
// srec_word_packer
//
// Packs the byte-write stream of the SREC parser into aligned 32-bit
// little-endian words with byte enables. Completed words are buffered in a
// small FIFO and handed to a valid/ready consumer. The byte source cannot be
// stalled, so a word that arrives while the FIFO is full is dropped and a
// sticky overflow flag is raised.
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   byte_address/data  incoming byte and its byte address
//   byte_valid         one-cycle byte strobe
//   flush              one-cycle request to emit any partial word
//   word_address       word-aligned address of the FIFO head ([1:0] = 0)
//   word_data          FIFO head data, lane k at bits [8k+7:8k]
//   word_byte_enable   FIFO head lane enables
//   word_valid         FIFO non-empty
//   word_ready         consumer accepts the head when valid && ready
//   overflow           sticky: a completed word was dropped (FIFO full)
//   busy               accumulator, FIFO or pending flush still active
// ---------------------------------------------------------------------------
module srec_word_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] byte_address,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        flush,
  output logic [31:0] word_address,
  output logic [31:0] word_data,
  output logic [3:0]  word_byte_enable,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        overflow,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Accumulator state
  logic [29:0]   acc_addr_q, acc_addr_d;
  logic [31:0]   acc_data_q, acc_data_d;
  logic [3:0]    acc_be_q, acc_be_d;
  logic          flush_pending_q, flush_pending_d;
  logic          overflow_q, overflow_d;

  // FIFO state
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [29:0]   fifo_addr_mem [FIFO_DEPTH];
  logic [31:0]   fifo_data_mem [FIFO_DEPTH];
  logic [3:0]    fifo_be_mem   [FIFO_DEPTH];

  // Incoming byte decoded into its lane position
  logic [29:0]   in_waddr;
  logic [3:0]    lane_be;
  logic [31:0]   lane_data;

  // Word offered to the FIFO this cycle
  logic          push;
  logic [29:0]   push_addr;
  logic [31:0]   push_data;
  logic [3:0]    push_be;
  logic [3:0]    merged_be;
  logic [31:0]   merged_data;

  logic          pop;
  logic          full;
  logic          push_ok;

  assign in_waddr = byte_address[31:2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_be[gi]             = (byte_address[1:0] == 2'(gi));
    assign lane_data[8*gi +: 8]    = (byte_address[1:0] == 2'(gi)) ? byte_data : 8'h00;
  end

  // Accumulator and flush handling. Unused lanes of acc_data are kept zero so
  // merging is a plain OR.
  always_comb begin
    acc_addr_d      = acc_addr_q;
    acc_data_d      = acc_data_q;
    acc_be_d        = acc_be_q;
    flush_pending_d = flush_pending_q;
    push            = 1'b0;
    push_addr       = acc_addr_q;
    push_data       = acc_data_q;
    push_be         = acc_be_q;
    merged_be       = acc_be_q | lane_be;
    merged_data     = acc_data_q | lane_data;

    if (byte_valid) begin
      if (acc_be_q == 4'h0) begin
        acc_addr_d = in_waddr;
        acc_data_d = lane_data;
        acc_be_d   = lane_be;
      end else if ((in_waddr == acc_addr_q) && ((acc_be_q & lane_be) == 4'h0)) begin
        if (merged_be == 4'hF) begin
          // Word completed by this byte: emit it now, leave acc empty
          push       = 1'b1;
          push_data  = merged_data;
          push_be    = merged_be;
          acc_data_d = 32'h0;
          acc_be_d   = 4'h0;
        end else begin
          acc_data_d = merged_data;
          acc_be_d   = merged_be;
        end
      end else begin
        // Different word or lane rewrite: emit the old word, restart with new byte
        push       = 1'b1;
        acc_addr_d = in_waddr;
        acc_data_d = lane_data;
        acc_be_d   = lane_be;
      end
    end else if (flush_pending_q) begin
      // A flush only acts in a byte-free cycle
      flush_pending_d = 1'b0;
      if (acc_be_q != 4'h0) begin
        push       = 1'b1;
        acc_data_d = 32'h0;
        acc_be_d   = 4'h0;
      end
    end

    if (flush) begin
      flush_pending_d = 1'b1;
    end
  end

  // FIFO control. A push into a full FIFO still succeeds when the head is
  // popped on the same edge.
  assign word_valid = (count_q != '0);
  assign pop        = word_valid & word_ready;
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign push_ok    = push & (~full | pop);

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = overflow_q | (push & full & ~pop);
    count_d    = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_addr_q      <= '0;
      acc_data_q      <= '0;
      acc_be_q        <= '0;
      flush_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      acc_addr_q      <= acc_addr_d;
      acc_data_q      <= acc_data_d;
      acc_be_q        <= acc_be_d;
      flush_pending_q <= flush_pending_d;
      overflow_q      <= overflow_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  // Storage needs no reset: the head outputs are masked while empty
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_addr_mem[wr_ptr_q] <= push_addr;
      fifo_data_mem[wr_ptr_q] <= push_data;
      fifo_be_mem[wr_ptr_q]   <= push_be;
    end
  end

  assign word_address     = word_valid ? {fifo_addr_mem[rd_ptr_q], 2'b00} : 32'h0;
  assign word_data        = word_valid ? fifo_data_mem[rd_ptr_q] : 32'h0;
  assign word_byte_enable = word_valid ? fifo_be_mem[rd_ptr_q] : 4'h0;
  assign overflow         = overflow_q;
  assign busy             = (acc_be_q != 4'h0) | word_valid | flush_pending_q;

endmodule

// File: tb/tb_srec_word_packer.sv
// ---------------------------------------------------------------------------
// tb_srec_word_packer
//
// Self-checking bench for srec_word_packer (FIFO_DEPTH = 4): a table of
// per-cycle vectors for the packing/flush behaviour, then hand-written
// sequences for overflow, drain, reset and push/pop while full.
// ---------------------------------------------------------------------------
module tb_srec_word_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] byte_address;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        flush;
  logic [31:0] word_address;
  logic [31:0] word_data;
  logic [3:0]  word_byte_enable;
  logic        word_valid;
  logic        word_ready;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  srec_word_packer #(.FIFO_DEPTH(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .byte_address     (byte_address),
    .byte_data        (byte_data),
    .byte_valid       (byte_valid),
    .flush            (flush),
    .word_address     (word_address),
    .word_data        (word_data),
    .word_byte_enable (word_byte_enable),
    .word_valid       (word_valid),
    .word_ready       (word_ready),
    .overflow         (overflow),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        bv;
    logic [31:0] addr;
    logic [7:0]  data;
    logic        fl;
    logic        rdy;
    logic        wv;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        ovf;
    logic        bsy;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic bv, input logic [31:0] addr, input logic [7:0] data,
                              input logic fl, input logic rdy, input logic wv,
                              input logic [31:0] waddr, input logic [31:0] wdata,
                              input logic [3:0] wbe, input logic ovf, input logic bsy);
    vec_t v;
    v.bv = bv; v.addr = addr; v.data = data; v.fl = fl; v.rdy = rdy;
    v.wv = wv; v.waddr = waddr; v.wdata = wdata; v.wbe = wbe; v.ovf = ovf; v.bsy = bsy;
    return v;
  endfunction

  // Expected address/data of the i-th test word used by the sequences
  function automatic logic [31:0] wadr(input int i);
    return 32'h1000 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] wdat(input int i);
    logic [31:0] d;
    for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(8'h40 + 4 * i + k);
    return d;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put_byte(input logic [31:0] a, input logic [7:0] d);
    byte_valid   = 1'b1;
    byte_address = a;
    byte_data    = d;
    step();
    byte_valid   = 1'b0;
  endtask

  task automatic put_word(input int i);
    for (int k = 0; k < 4; k++) put_byte(wadr(i) + 32'(k), 8'(8'h40 + 4 * i + k));
  endtask

  task automatic check_head(input string name, input int i);
    check(name, {39'h0, word_valid, word_address, word_byte_enable},
                {39'h0, 1'b1, wadr(i), 4'hF});
    check({name, "_data"}, {40'h0, word_data}, {40'h0, wdat(i)});
  endtask

  initial begin
    reset        = 1'b1;
    byte_address = '0;
    byte_data    = '0;
    byte_valid   = 1'b0;
    flush        = 1'b0;
    word_ready   = 1'b1;

    // Per-cycle vectors: inputs applied for one edge, outputs checked after it
    //               bv    addr      data  fl    rdy   wv    waddr     wdata         wbe   ovf   busy
    vecs[0]  = mk(1'b1, 32'h100, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1);
    vecs[1]  = mk(1'b1, 32'h101, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 32'h102, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1);
    vecs[3]  = mk(1'b1, 32'h103, 8'h44, 1'b0, 1'b1, 1'b1, 32'h100, 32'h44332211, 4'hF, 1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 32'h201, 8'hAA, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1);
    vecs[6]  = mk(1'b1, 32'h202, 8'hBB, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 32'h300, 8'hCC, 1'b0, 1'b1, 1'b1, 32'h200, 32'h00BBAA00, 4'h6, 1'b0, 1'b1);
    vecs[8]  = mk(1'b0, 32'h0,   8'h00, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 32'h300, 32'h000000CC, 4'h1, 1'b0, 1'b1);
    vecs[10] = mk(1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 32'h10,  8'h55, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1);
    vecs[12] = mk(1'b1, 32'h10,  8'h66, 1'b1, 1'b1, 1'b1, 32'h10,  32'h00000055, 4'h1, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 32'h10,  32'h00000066, 4'h1, 1'b0, 1'b1);
    vecs[14] = mk(1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 32'h0,   8'h00, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1);
    vecs[16] = mk(1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0);

    step();
    step();
    reset = 1'b0;
    check("reset_state", {word_valid, word_address, word_data, word_byte_enable, overflow, busy},
                         {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0});

    for (int n = 0; n < 17; n++) begin
      byte_valid   = vecs[n].bv;
      byte_address = vecs[n].addr;
      byte_data    = vecs[n].data;
      flush        = vecs[n].fl;
      word_ready   = vecs[n].rdy;
      step();
      byte_valid = 1'b0;
      flush      = 1'b0;
      check($sformatf("vec%0d", n),
            {word_valid, word_address, word_data, word_byte_enable, overflow, busy},
            {vecs[n].wv, vecs[n].waddr, vecs[n].wdata, vecs[n].wbe, vecs[n].ovf, vecs[n].bsy});
    end

    // Overflow: five full words with the consumer stalled
    word_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put_word(i);
      check($sformatf("ovf_after_word%0d", i), {71'h0, overflow}, {71'h0, (i == 4)});
    end
    check_head("hold_head", 0);
    step();
    check_head("hold_head2", 0);

    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i), i);
      step();
    end
    check("drain_empty", {70'h0, word_valid, overflow}, {70'h0, 1'b0, 1'b1});

    // Reset with a partial word and a non-empty FIFO
    word_ready = 1'b0;
    put_word(20);
    put_word(21);
    put_byte(32'h2000, 8'h01);
    put_byte(32'h2001, 8'h02);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset", {word_valid, word_address, word_data, word_byte_enable, overflow, busy},
                       {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0});
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("reset_flush_pend", {70'h0, word_valid, busy}, {70'h0, 1'b0, 1'b1});
    step();
    check("reset_flush_none", {70'h0, word_valid, busy}, {70'h0, 1'b0, 1'b0});

    // Push and pop on the same edge while full
    for (int i = 10; i < 14; i++) put_word(i);
    for (int k = 0; k < 3; k++) put_byte(wadr(14) + 32'(k), 8'(8'h40 + 4 * 14 + k));
    word_ready = 1'b1;
    put_byte(wadr(14) + 32'd3, 8'(8'h40 + 4 * 14 + 3));
    word_ready = 1'b0;
    check("full_pushpop_ovf", {71'h0, overflow}, {71'h0, 1'b0});
    check_head("full_pushpop_head", 11);
    word_ready = 1'b1;
    for (int i = 11; i < 15; i++) begin
      check_head($sformatf("pp_drain%0d", i), i);
      step();
    end
    check("pp_empty", {70'h0, word_valid, overflow}, {70'h0, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
